// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: direction-counter encoding
// and BTB index/tag extraction.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  function automatic logic ctr_taken(input ctr_t c);
    return (c == CTR_WT) || (c == CTR_ST);
  endfunction

  function automatic int unsigned bp_idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned bp_tag_w(input int unsigned size, input int unsigned entries);
    return size - $clog2(entries) - 2;
  endfunction

  // Callers zero-extend the PC to 64 bits and truncate the result to IDX/TAG width.
  function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating direction counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    case (ctr_i)
      CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
      default: ctr_o = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: same-cycle lookup for fetch,
// training from execute's resolved-branch channel, plus branch/mispredict statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid_i,
  input  logic [SIZE-1:0] fetch_pc_i,
  output logic            predict_taken_o,
  output logic [SIZE-1:0] predict_target_o,
  input  logic            update_valid_i,
  input  logic [SIZE-1:0] update_pc_i,
  input  logic            update_taken_i,
  input  logic [SIZE-1:0] update_target_i,
  input  logic            misprediction_i,
  output logic [31:0]     branch_count_o,
  output logic [31:0]     mispredict_count_o
);

  localparam int unsigned IDX = bp_idx_w(ENTRIES);
  localparam int unsigned TAG = bp_tag_w(SIZE, ENTRIES);
  localparam int unsigned TGT = SIZE - 2;

  typedef struct packed {
    logic           valid;
    logic [TAG-1:0] tag;
    logic [TGT-1:0] target;
    ctr_t           ctr;
  } btb_entry_t;

  logic           valid_q [ENTRIES];
  ctr_t           ctr_q   [ENTRIES];
  logic [TAG-1:0] tag_q   [ENTRIES];
  logic [TGT-1:0] tgt_q   [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX-1:0] f_idx, u_idx;
  logic [TAG-1:0] f_tag, u_tag;
  btb_entry_t     f_ent, u_ent;
  logic           f_hit, u_hit;
  logic           alloc_en, hit_upd_en;
  ctr_t           ctr_next;
  logic           unused_bits;

  assign f_idx = IDX'(bp_index(64'(fetch_pc_i), IDX));
  assign f_tag = TAG'(bp_tag(64'(fetch_pc_i), IDX));
  assign u_idx = IDX'(bp_index(64'(update_pc_i), IDX));
  assign u_tag = TAG'(bp_tag(64'(update_pc_i), IDX));
  assign unused_bits = ^update_target_i[1:0];

  always_comb begin
    f_ent = '{valid: valid_q[f_idx], tag: tag_q[f_idx], target: tgt_q[f_idx], ctr: ctr_q[f_idx]};
    u_ent = '{valid: valid_q[u_idx], tag: tag_q[u_idx], target: tgt_q[u_idx], ctr: ctr_q[u_idx]};
    f_hit = fetch_valid_i & f_ent.valid & (f_ent.tag == f_tag);
    u_hit = u_ent.valid & (u_ent.tag == u_tag);
    predict_taken_o  = f_hit & ctr_taken(f_ent.ctr);
    predict_target_o = predict_taken_o ? {f_ent.target, 2'b00} : '0;
    alloc_en   = update_valid_i & ~u_hit & update_taken_i;
    hit_upd_en = update_valid_i & u_hit;
  end

  bp_sat_counter u_sat_counter (
    .ctr_i   (u_ent.ctr),
    .taken_i (update_taken_i),
    .ctr_o   (ctr_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (alloc_en) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]   <= CTR_ALLOC;
    end else if (hit_upd_en) begin
      ctr_q[u_idx] <= ctr_next;
    end
  end

  // Tag/target carry no reset; valid gating makes their post-reset contents irrelevant.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      tag_q[u_idx] <= u_tag;
    end
    if (alloc_en || (hit_upd_en && update_taken_i)) begin
      tgt_q[u_idx] <= update_target_i[SIZE-1:2];
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q + 32'(update_valid_i);
    mispredict_cnt_d = mispredict_cnt_q + 32'(update_valid_i & misprediction_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispredict_cnt_q;

endmodule
